// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory store buffer.
//   wb_entry_t : one posted store {widx, data, be}
//   BE_WORD    : byte enables of a full-word store
//   MEMW_WORD / MEMW_BYTE : memwidth encoding (0 = SW, 1 = SB)
//   lane_be()  : one-hot byte enable for a byte lane
//   byte_rep() : replicate a byte into all four lanes
package mem_pkg;

  // The word index is kept at its widest possible size (aluout[31:2]) so the
  // struct does not depend on the array size; users compare only the low
  // ADDRW bits.
  localparam int WIDX_W = 30;

  localparam logic [3:0] BE_WORD   = 4'b1111;
  localparam logic       MEMW_WORD = 1'b0;
  localparam logic       MEMW_BYTE = 1'b1;

  typedef struct packed {
    logic [WIDX_W-1:0] widx;
    logic [31:0]       data;
    logic [3:0]        be;
  } wb_entry_t;

  // Little-endian: lane 0 is bits 7:0.
  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    lane_be = 4'b0001 << lane;
  endfunction

  function automatic logic [31:0] byte_rep(input logic [7:0] b);
    byte_rep = {4{b}};
  endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// CPU data port as seen by the data memory.
//   master : the CPU (drives memwrite/memread/memwidth/aluout/writedata)
//   slave  : the memory (returns readdata and buffer occupancy)
interface dmem_store_buffer_if #(
  parameter int DEPTH = 4
);
  logic                     memwrite;
  logic                     memread;
  logic                     memwidth;
  logic [31:0]              aluout;
  logic [31:0]              writedata;
  logic [31:0]              readdata;
  logic [$clog2(DEPTH):0]   wb_count;
  logic                     wb_empty;

  modport master (
    output memwrite, memread, memwidth, aluout, writedata,
    input  readdata, wb_count, wb_empty
  );

  modport slave (
    input  memwrite, memread, memwidth, aluout, writedata,
    output readdata, wb_count, wb_empty
  );
endinterface

// File: rtl/wb_forward_merge.sv
// Store-to-load forwarding merge (purely combinational).
//   arr_word : word read from the backing array at widx
//   entries  : store-buffer storage, indexed by slot
//   valid    : per-slot valid flags
//   head     : slot of the oldest entry
//   widx     : word index being looked up
//   merged   : arr_word overlaid by every matching valid entry, oldest first,
//              per byte lane, so the youngest store to each byte wins
module wb_forward_merge
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDRW = 6
) (
  input  logic [31:0]              arr_word,
  input  wb_entry_t                entries [DEPTH],
  input  logic [DEPTH-1:0]         valid,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [ADDRW-1:0]         widx,
  output logic [31:0]              merged
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;
  logic          unused_widx_hi;

  always_comb begin
    merged         = arr_word;
    idx            = '0;
    unused_widx_hi = 1'b0;
    // Walk slots from the head (oldest) forward; pointer arithmetic wraps
    // naturally because DEPTH is a power of two.
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && (entries[idx].widx[ADDRW-1:0] == widx)) begin
        for (int l = 0; l < 4; l++) begin
          if (entries[idx].be[l]) begin
            merged[l*8 +: 8] = entries[idx].data[l*8 +: 8];
          end
        end
      end
      unused_widx_hi = unused_widx_hi ^ (^entries[k].widx[WIDX_W-1:ADDRW]);
    end
  end
endmodule

// File: rtl/dmem_store_buffer.sv
// Data memory with a posted store buffer for a single-cycle MIPS core.
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous, active-low; clears the buffer, not the array
//   bus   : slave side of the CPU data port (see dmem_store_buffer_if)
// Stores enter the buffer on their own cycle and drain to the array one per
// non-load cycle. Loads read the array merged with pending stores, so the CPU
// sees program-order memory with zero-latency reads.
module dmem_store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDRW = 6
) (
  input  logic               clk,
  input  logic               reset,
  dmem_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]      mem [2**ADDRW];
  wb_entry_t        entries_reg [DEPTH];
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;

  logic             full;
  logic             do_drain;
  logic             do_push;
  logic [DEPTH-1:0] valid;
  wb_entry_t        push_entry;
  wb_entry_t        head_entry;
  logic [ADDRW-1:0] lookup_widx;
  logic [ADDRW-1:0] drain_widx;
  logic [31:0]      arr_word;
  logic             unused_bits;

  assign lookup_widx = bus.aluout[ADDRW+1:2];
  assign head_entry  = entries_reg[head_reg];
  assign drain_widx  = head_entry.widx[ADDRW-1:0];
  assign unused_bits = ^{bus.aluout[31:ADDRW+2], head_entry.widx[WIDX_W-1:ADDRW]};

  // Loads own the array read port, so a load cycle holds the buffer. A store
  // with a load (never issued by the CPU) therefore cannot drain and, when
  // the buffer is full, is dropped.
  assign full     = (count_reg == CW'(DEPTH));
  assign do_drain = (count_reg != '0) && !bus.memread;
  assign do_push  = bus.memwrite && (!full || do_drain);

  always_comb begin
    push_entry.widx = {{(WIDX_W-ADDRW){1'b0}}, bus.aluout[ADDRW+1:2]};
    if (bus.memwidth == MEMW_BYTE) begin
      push_entry.be   = lane_be(bus.aluout[1:0]);
      push_entry.data = byte_rep(bus.writedata[7:0]);
    end else begin
      push_entry.be   = BE_WORD;
      push_entry.data = bus.writedata;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_drain})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push)  tail_reg <= tail_reg + PW'(1);
      if (do_drain) head_reg <= head_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Payload storage needs no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (do_push) entries_reg[tail_reg] <= push_entry;
  end

  // Backing array: byte-enabled write of the head entry on a drain.
  always_ff @(posedge clk) begin
    if (do_drain) begin
      for (int l = 0; l < 4; l++) begin
        if (head_entry.be[l]) mem[drain_widx][l*8 +: 8] <= head_entry.data[l*8 +: 8];
      end
    end
  end

  assign arr_word = mem[lookup_widx];

  // Slot gi is valid when its distance from head is below the count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [PW-1:0] age;
      assign age       = PW'(gi) - head_reg;
      assign valid[gi] = ({1'b0, age} < count_reg);
    end
  endgenerate

  wb_forward_merge #(
    .DEPTH (DEPTH),
    .ADDRW (ADDRW)
  ) u_merge (
    .arr_word (arr_word),
    .entries  (entries_reg),
    .valid    (valid),
    .head     (head_reg),
    .widx     (lookup_widx),
    .merged   (bus.readdata)
  );

  assign bus.wb_count = count_reg;
  assign bus.wb_empty = (count_reg == '0);
endmodule
